rx_frame_ctrl: RTL and testbench
================================

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 520000, inter-byte timeout in clk cycles (50 bit times at 10400 clk/bit).
REQ-002 Parameter MAX_LEN, default 8, maximum payload bytes per frame.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 rx_data  in  8  byte from UART receiver, valid only with rx_valid.
REQ-006 rx_valid  in  1  one-cycle strobe, byte received.
REQ-007 rx_en  out  1  receive enable to UART receiver.
REQ-008 frm_cmd  out  8  command byte of held frame.
REQ-009 frm_len  out  4  payload length of held frame.
REQ-010 frm_addr  in  3  payload read index.
REQ-011 frm_data  out  8  payload byte at frm_addr.
REQ-012 frm_valid  out  1  level, complete checked frame held.
REQ-013 frm_ack  in  1  consumer releases held frame.
REQ-014 err_chk  out  1  one-cycle pulse, checksum mismatch.
REQ-015 err_len  out  1  one-cycle pulse, LEN > MAX_LEN.
REQ-016 err_tout  out  1  one-cycle pulse, inter-byte timeout.

Function
REQ-017 Frame format SHALL be: SOF 0xAA, CMD, LEN, LEN payload bytes, CHK = XOR of CMD, LEN and all payload bytes.
REQ-018 States SHALL be IDLE, CMD, LEN, PAY, CHK, HOLD; one transition per accepted rx_valid byte except HOLD exit and error exits.
REQ-019 IDLE: byte 0xAA -> CMD; any other byte discarded, no error.
REQ-020 CMD: store byte in frm_cmd register, init running XOR with it -> LEN.
REQ-021 LEN: LEN > MAX_LEN -> err_len pulse, -> IDLE; LEN = 0 -> CHK; else store, -> PAY.
REQ-022 PAY: write byte to buffer at index count, count increments; after LEN-th byte -> CHK.
REQ-023 CHK: byte equal to running XOR -> HOLD; else err_chk pulse, -> IDLE, frm_valid stays 0.
REQ-024 HOLD: frm_valid = 1, rx_en = 0, incoming rx_valid ignored; frm_ack -> IDLE, frm_valid low and rx_en high on the following cycle.
REQ-025 rx_en SHALL be 1 in all states except HOLD.
REQ-026 frm_data SHALL be combinational buffer[frm_addr] when frm_valid = 1, else 0x00; frm_addr >= frm_len returns stale buffer content.
REQ-027 Timeout counter SHALL clear on every rx_valid and whenever in IDLE or HOLD; counts in CMD/LEN/PAY/CHK; reaching TIMEOUT_CYCLES-1 -> err_tout pulse, -> IDLE.
REQ-028 rx_valid and timeout in same cycle: byte SHALL win, no err_tout.
REQ-029 frm_ack outside HOLD SHALL be ignored.
REQ-030 Error pulses SHALL be mutually exclusive and last exactly one cycle, asserted the cycle after the offending byte.
REQ-031 Running XOR and all counters SHALL be fixed width, wrap-free by construction (count 0..MAX_LEN, 4 bits).

Reset
REQ-032 reset low SHALL immediately force IDLE, rx_en = 1, frm_valid = 0, frm_cmd = 0, frm_len = 0, all error pulses 0, counters and XOR 0; buffer contents need not clear.
REQ-033 reset asserted mid-frame SHALL discard the partial frame; first byte after release is treated as IDLE input.

Structure
REQ-034 Shared package/include SHALL hold SOF value 0xAA, state encodings and default MAX_LEN.
REQ-035 Payload storage SHALL be one sub-module rx_frame_buf (MAX_LEN x 8 registers, one write port, one async read port).

Verification
REQ-036 Bytes AA 01 02 10 20 33 -> frm_valid = 1, frm_cmd 0x01, frm_len 2, addr0 0x10, addr1 0x20, rx_en 0; frm_ack -> frm_valid 0 next cycle.
REQ-037 Bytes AA 01 02 10 20 00 -> single err_chk pulse, frm_valid stays 0, next frame AA 05 00 05 accepted.
REQ-038 Bytes 55 13 AA 07 09 -> leading 55 13 ignored, err_len pulse after 09, state IDLE.
REQ-039 Bytes AA 01 then silence -> err_tout exactly TIMEOUT_CYCLES cycles after last rx_valid; byte arriving on final count cycle suppresses it.
REQ-040 reset low after AA 01 02 10, release, send AA 02 01 7F 7C -> frm_cmd 0x02, frm_len 1, addr0 0x7F, no error pulses.

Source files
------------

// File: rtl/rx_frame_ctrl_pkg.sv
// ============================================================================
// Module      : rx_frame_ctrl_pkg
// Description : Shared constants for the UART frame receiver: start-of-frame
//               marker, FSM state encodings and default payload limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_frame_ctrl_pkg;

   // Start-of-frame marker byte
   localparam logic [7:0] c_SOF = 8'hAA;

   // Default maximum payload length in bytes
   localparam int c_MAX_LEN_DEF = 8;

   // Receiver FSM state encodings
   localparam logic [2:0] c_ST_IDLE = 3'd0;
   localparam logic [2:0] c_ST_CMD  = 3'd1;
   localparam logic [2:0] c_ST_LEN  = 3'd2;
   localparam logic [2:0] c_ST_PAY  = 3'd3;
   localparam logic [2:0] c_ST_CHK  = 3'd4;
   localparam logic [2:0] c_ST_HOLD = 3'd5;

   // True for the states in which the inter-byte timeout is armed
   function automatic logic is_timed_state(input logic [2:0] st);
      return (st == c_ST_CMD) || (st == c_ST_LEN) ||
             (st == c_ST_PAY) || (st == c_ST_CHK);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rx_frame_buf.sv
// ============================================================================
// Module      : rx_frame_buf
// Description : Payload byte store; one synchronous write port and one
//               asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_frame_buf #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [DEPTH];

   // Store one payload byte per write strobe
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Asynchronous read; addresses beyond the store read as zero
   always_comb begin
      o_rdata = 8'h00;
      if (int'(i_raddr) < DEPTH) begin
         o_rdata = r_mem[i_raddr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/rx_frame_ctrl.sv
// ============================================================================
// Module      : rx_frame_ctrl
// Description : Parses SOF/CMD/LEN/payload/CHK frames from a UART byte
//               stream, validates length and XOR checksum, holds a good
//               frame until acknowledged and flags errors/timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_frame_ctrl
   import rx_frame_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 520000,
   parameter int MAX_LEN        = c_MAX_LEN_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_valid,
   output logic       o_rx_en,
   output logic [7:0] o_frm_cmd,
   output logic [3:0] o_frm_len,
   input  logic [2:0] i_frm_addr,
   output logic [7:0] o_frm_data,
   output logic       o_frm_valid,
   input  logic       i_frm_ack,
   output logic       o_err_chk,
   output logic       o_err_len,
   output logic       o_err_tout
);

   // Timeout counter only needs to reach TIMEOUT_CYCLES-1 before it is cleared
   localparam int             TW          = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  c_TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]  c_TOUT_ONE  = TW'(1);

   logic [2:0]    r_state;
   logic [2:0]    w_state_nxt;
   logic [7:0]    r_cmd;
   logic [3:0]    r_len;
   logic [3:0]    r_cnt;
   logic [3:0]    w_cnt_inc;
   logic [7:0]    r_xor;
   logic [TW-1:0] r_tout_cnt;
   logic          r_err_chk;
   logic          r_err_len;
   logic          r_err_tout;
   logic          w_err_chk;
   logic          w_err_len;
   logic          w_err_tout;
   logic          w_len_big;
   logic          w_tout_hit;
   logic          w_hold;
   logic          w_buf_we;
   logic [7:0]    w_buf_rdata;

   assign w_cnt_inc  = r_cnt + 4'd1;
   assign w_len_big  = (i_rx_data > 8'(MAX_LEN));
   assign w_tout_hit = (r_tout_cnt == c_TOUT_LAST);
   assign w_buf_we   = i_rx_valid && (r_state == c_ST_PAY);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and error decisions; a received byte always beats the timeout
   always_comb begin
      w_state_nxt = r_state;
      w_err_chk   = 1'b0;
      w_err_len   = 1'b0;
      w_err_tout  = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            if (i_rx_valid && (i_rx_data == c_SOF)) begin
               w_state_nxt = c_ST_CMD;
            end
         end
         c_ST_CMD: begin
            if (i_rx_valid) begin
               w_state_nxt = c_ST_LEN;
            end else if (w_tout_hit) begin
               w_state_nxt = c_ST_IDLE;
               w_err_tout  = 1'b1;
            end
         end
         c_ST_LEN: begin
            if (i_rx_valid) begin
               if (w_len_big) begin
                  w_state_nxt = c_ST_IDLE;
                  w_err_len   = 1'b1;
               end else if (i_rx_data == 8'h00) begin
                  w_state_nxt = c_ST_CHK;
               end else begin
                  w_state_nxt = c_ST_PAY;
               end
            end else if (w_tout_hit) begin
               w_state_nxt = c_ST_IDLE;
               w_err_tout  = 1'b1;
            end
         end
         c_ST_PAY: begin
            if (i_rx_valid) begin
               if (w_cnt_inc == r_len) begin
                  w_state_nxt = c_ST_CHK;
               end
            end else if (w_tout_hit) begin
               w_state_nxt = c_ST_IDLE;
               w_err_tout  = 1'b1;
            end
         end
         c_ST_CHK: begin
            if (i_rx_valid) begin
               if (i_rx_data == r_xor) begin
                  w_state_nxt = c_ST_HOLD;
               end else begin
                  w_state_nxt = c_ST_IDLE;
                  w_err_chk   = 1'b1;
               end
            end else if (w_tout_hit) begin
               w_state_nxt = c_ST_IDLE;
               w_err_tout  = 1'b1;
            end
         end
         c_ST_HOLD: begin
            if (i_frm_ack) begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from state; payload reads as zero unless a frame is held
   always_comb begin
      w_hold      = (r_state == c_ST_HOLD);
      o_rx_en     = !w_hold;
      o_frm_valid = w_hold;
      o_frm_data  = w_hold ? w_buf_rdata : 8'h00;
   end

   // Frame fields, running checksum, payload index, timeout and error pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd      <= 8'h00;
         r_len      <= 4'd0;
         r_cnt      <= 4'd0;
         r_xor      <= 8'h00;
         r_tout_cnt <= '0;
         r_err_chk  <= 1'b0;
         r_err_len  <= 1'b0;
         r_err_tout <= 1'b0;
      end else begin
         r_err_chk  <= w_err_chk;
         r_err_len  <= w_err_len;
         r_err_tout <= w_err_tout;

         if (i_rx_valid || !is_timed_state(r_state)) begin
            r_tout_cnt <= '0;
         end else begin
            r_tout_cnt <= r_tout_cnt + c_TOUT_ONE;
         end

         if (i_rx_valid) begin
            case (r_state)
               c_ST_CMD: begin
                  r_cmd <= i_rx_data;
                  r_xor <= i_rx_data;
               end
               c_ST_LEN: begin
                  r_cnt <= 4'd0;
                  if (!w_len_big) begin
                     r_len <= i_rx_data[3:0];
                     r_xor <= r_xor ^ i_rx_data;
                  end
               end
               c_ST_PAY: begin
                  r_xor <= r_xor ^ i_rx_data;
                  r_cnt <= w_cnt_inc;
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign o_frm_cmd  = r_cmd;
   assign o_frm_len  = r_len;
   assign o_err_chk  = r_err_chk;
   assign o_err_len  = r_err_len;
   assign o_err_tout = r_err_tout;

   rx_frame_buf #(
      .DEPTH (MAX_LEN),
      .AW    (3)
   ) u_buf (
      .clk     (clk),
      .i_we    (w_buf_we),
      .i_waddr (r_cnt[2:0]),
      .i_wdata (i_rx_data),
      .i_raddr (i_frm_addr),
      .o_rdata (w_buf_rdata)
   );

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
// ============================================================================
// Module      : tb_rx_frame_ctrl
// Description : Self-checking bench for rx_frame_ctrl with directed frames
//               and randomized frame traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rx_frame_ctrl;

   localparam int TOUT = 40;
   localparam int MAXL = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] i_rx_data = 8'h00;
   logic       i_rx_valid = 1'b0;
   logic       o_rx_en;
   logic [7:0] o_frm_cmd;
   logic [3:0] o_frm_len;
   logic [2:0] i_frm_addr = 3'd0;
   logic [7:0] o_frm_data;
   logic       o_frm_valid;
   logic       i_frm_ack = 1'b0;
   logic       o_err_chk;
   logic       o_err_len;
   logic       o_err_tout;

   always #5 clk = ~clk;

   rx_frame_ctrl #(
      .TIMEOUT_CYCLES (TOUT),
      .MAX_LEN        (MAXL)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rx_data   (i_rx_data),
      .i_rx_valid  (i_rx_valid),
      .o_rx_en     (o_rx_en),
      .o_frm_cmd   (o_frm_cmd),
      .o_frm_len   (o_frm_len),
      .i_frm_addr  (i_frm_addr),
      .o_frm_data  (o_frm_data),
      .o_frm_valid (o_frm_valid),
      .i_frm_ack   (i_frm_ack),
      .o_err_chk   (o_err_chk),
      .o_err_len   (o_err_len),
      .o_err_tout  (o_err_tout)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: bytes of the frame in progress after SOF, held frame
   bit         m_in_frame = 1'b0;
   bit         m_hold     = 1'b0;
   int         m_sil      = 0;
   logic [7:0] m_q[$];
   logic [7:0] m_cmd;
   logic [7:0] m_len;
   logic [7:0] m_pay[MAXL];
   bit         e_chk;
   bit         e_len;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Frame-level interpretation of one received byte
   task automatic model_byte(input logic [7:0] b);
      logic [7:0] x;
      e_chk = 1'b0;
      e_len = 1'b0;
      m_sil = 0;
      if (m_hold) return;
      if (!m_in_frame) begin
         if (b == 8'hAA) begin
            m_in_frame = 1'b1;
            m_q.delete();
         end
         return;
      end
      m_q.push_back(b);
      if (m_q.size() == 2 && m_q[1] > MAXL) begin
         e_len      = 1'b1;
         m_in_frame = 1'b0;
      end else if (m_q.size() >= 2 && m_q.size() == int'(m_q[1]) + 3) begin
         x = 8'h00;
         for (int i = 0; i < m_q.size() - 1; i++) x ^= m_q[i];
         if (x == b) begin
            m_hold = 1'b1;
            m_cmd  = m_q[0];
            m_len  = m_q[1];
            for (int i = 0; i < int'(m_len); i++) m_pay[i] = m_q[2 + i];
         end else begin
            e_chk = 1'b1;
         end
         m_in_frame = 1'b0;
      end
   endtask

   // Verify the held frame contents through the read port
   task automatic check_hold();
      check("hold_cmd", o_frm_cmd, m_cmd);
      check("hold_len", o_frm_len, m_len);
      check("hold_rx_en", o_rx_en, 1'b0);
      for (int i = 0; i < int'(m_len); i++) begin
         i_frm_addr = 3'(i);
         tick();
         check($sformatf("hold_data[%0d]", i), o_frm_data, m_pay[i]);
      end
      i_frm_addr = 3'd0;
   endtask

   task automatic send(input logic [7:0] b);
      bit was_hold;
      was_hold   = m_hold;
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
      i_rx_data  = 8'($urandom);
      model_byte(b);
      check("err_chk", o_err_chk, e_chk);
      check("err_len", o_err_len, e_len);
      check("err_tout", o_err_tout, 1'b0);
      check("frm_valid", o_frm_valid, m_hold);
      check("rx_en", o_rx_en, !m_hold);
      if (m_hold && !was_hold) check_hold();
   endtask

   // Silent cycles; stray acks outside HOLD must be ignored
   task automatic idle(input int n);
      bit exp_t;
      for (int k = 0; k < n; k++) begin
         i_frm_ack = (!m_hold && ($urandom_range(0, 7) == 0));
         tick();
         i_frm_ack = 1'b0;
         m_sil++;
         exp_t = m_in_frame && (m_sil == TOUT);
         if (exp_t) m_in_frame = 1'b0;
         check("idle_err_tout", o_err_tout, exp_t);
         check("idle_err_other", {o_err_chk, o_err_len}, 2'b00);
         check("idle_frm_valid", o_frm_valid, m_hold);
      end
   endtask

   task automatic release_frame();
      i_frm_ack = 1'b1;
      tick();
      i_frm_ack = 1'b0;
      m_hold    = 1'b0;
      check("ack_frm_valid", o_frm_valid, 1'b0);
      check("ack_rx_en", o_rx_en, 1'b1);
      check("ack_frm_data", o_frm_data, 8'h00);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_rx_en", o_rx_en, 1'b1);
      check("rst_frm_valid", o_frm_valid, 1'b0);
      check("rst_frm_cmd", o_frm_cmd, 8'h00);
      check("rst_frm_len", o_frm_len, 4'd0);
      check("rst_errs", {o_err_chk, o_err_len, o_err_tout}, 3'b000);
      tick();
      rst_n      = 1'b1;
      m_in_frame = 1'b0;
      m_hold     = 1'b0;
      m_sil      = 0;
      tick();
   endtask

   task automatic send_seq(input logic [7:0] s[$], input int gap);
      foreach (s[j]) begin
         send(s[j]);
         if (gap > 0) idle(gap);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] s[$];

      do_reset();

      // Good frame, back-to-back bytes
      s = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
      send_seq(s, 0);
      check("d36_valid", o_frm_valid, 1'b1);
      check("d36_cmd", o_frm_cmd, 8'h01);
      check("d36_len", o_frm_len, 4'd2);
      check("d36_rx_en", o_rx_en, 1'b0);
      idle(2);
      release_frame();

      // Bad checksum then a zero-length frame
      s = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h00};
      send_seq(s, 1);
      check("d37_valid", o_frm_valid, 1'b0);
      s = '{8'hAA, 8'h05, 8'h00, 8'h05};
      send_seq(s, 1);
      check("d37_cmd", o_frm_cmd, 8'h05);
      check("d37_len", o_frm_len, 4'd0);
      release_frame();

      // Leading junk then oversize length
      s = '{8'h55, 8'h13, 8'hAA, 8'h07, 8'h09};
      send_seq(s, 1);
      s = '{8'hAA, 8'h00, 8'h00, 8'h00};
      send_seq(s, 1);
      check("d38_idle_after_len", o_frm_valid, 1'b1);
      release_frame();

      // Inter-byte timeout, then a byte on the final count cycle
      s = '{8'hAA, 8'h01};
      send_seq(s, 0);
      idle(TOUT + 2);
      send_seq(s, 0);
      idle(TOUT - 1);
      s = '{8'h02, 8'h10, 8'h20, 8'h33};
      send_seq(s, 0);
      check("d39_valid", o_frm_valid, 1'b1);
      release_frame();

      // Reset mid-frame discards partial frame
      s = '{8'hAA, 8'h01, 8'h02, 8'h10};
      send_seq(s, 1);
      do_reset();
      s = '{8'hAA, 8'h02, 8'h01, 8'h7F, 8'h7C};
      send_seq(s, 1);
      check("d40_cmd", o_frm_cmd, 8'h02);
      check("d40_len", o_frm_len, 4'd1);
      check("d40_valid", o_frm_valid, 1'b1);
      release_frame();

      // Randomized frame traffic
      for (int f = 0; f < 80; f++) begin
         int         kind;
         int         len;
         int         ndrop;
         logic [7:0] x;
         logic [7:0] c;
         logic [7:0] d;
         logic [7:0] fb[$];
         fb.delete();
         kind = $urandom_range(0, 6);
         if (kind == 4) begin
            repeat ($urandom_range(1, 3)) fb.push_back(8'($urandom_range(0, 8'hA9)));
         end
         len = $urandom_range(0, MAXL);
         c   = 8'($urandom);
         fb.push_back(8'hAA);
         fb.push_back(c);
         if (kind == 3) begin
            fb.push_back(8'($urandom_range(MAXL + 1, 255)));
         end else begin
            fb.push_back(8'(len));
            x = c ^ 8'(len);
            for (int i = 0; i < len; i++) begin
               d = 8'($urandom);
               fb.push_back(d);
               x ^= d;
            end
            if (kind == 2) fb.push_back(x ^ 8'($urandom_range(1, 255)));
            else           fb.push_back(x);
            if (kind == 5) begin
               ndrop = $urandom_range(1, fb.size() - 1);
               repeat (ndrop) void'(fb.pop_back());
            end
         end
         for (int j = 0; j < fb.size(); j++) begin
            if (j > 0) begin
               if (kind == 6 && j == fb.size() - 1) idle(TOUT - 1);
               else                                 idle($urandom_range(0, 3));
            end
            send(fb[j]);
         end
         if (kind == 5) idle(TOUT + 2);
         else           idle($urandom_range(1, 3));
         if (m_hold) begin
            if ($urandom_range(0, 1) == 1) send(8'hAA);
            idle($urandom_range(0, 2));
            release_frame();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
